// File: rtl/mcu_spi_slave.sv
// -----------------------------------------------------------------------------
// mcu_spi_slave
//   SPI mode-0 responder for the board MCU. The SPI pins are oversampled in the
//   clk28 domain, transfers are framed by chip select, and received bytes are
//   delivered as single-cycle strobes: the first byte of a frame is the command,
//   and every later byte is data. A host-supplied byte is returned on MISO
//   during each byte slot.
//
// Ports
//   clk28        system clock (28 MHz)
//   rst_n        asynchronous reset, active low
//   spi_cs_n     chip select from MCU, active low
//   spi_sck      SPI clock from MCU, idle low
//   spi_mosi     serial data from MCU, MSB first
//   spi_miso     serial data to MCU, MSB first (1 when not selected)
//   tx_data      byte to return in the next slot, sampled on load events
//   tx_req       pulse: tx_data is loaded at the next SCK falling edge
//   rx_cmd       first byte of the current frame
//   rx_cmd_stb   pulse when rx_cmd updates
//   rx_data      most recent non-first byte
//   rx_data_stb  pulse when rx_data updates
//   rx_index     data byte index within frame, saturating at 255
//   frame_end    pulse on chip select deassertion
// -----------------------------------------------------------------------------
module mcu_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_cmd,
  output logic       rx_cmd_stb,
  output logic [7:0] rx_data,
  output logic       rx_data_stb,
  output logic [7:0] rx_index,
  output logic       frame_end
);

  // SETTLE waits for the synchronisers to reflect the real pins after reset,
  // and then for CS to be seen high, so a frame already running at release is
  // ignored rather than picked up half way through.
  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_FRAME
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SYNC_STAGES);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic       cs_s, sck_s, mosi_s, sck_d;
  logic       sck_rise, sck_fall, in_frame;
  logic       frame_start, frame_stop;
  logic [3:0] settle_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shreg;
  logic [7:0] rx_byte;
  logic [7:0] tx_shreg;
  logic       first_byte, data_seen, reload_pending;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign in_frame = (state == ST_FRAME);
  assign rx_byte  = {rx_shreg, mosi_s};
  assign spi_miso = in_frame ? tx_shreg[7] : 1'b1;

  // Synchronisers reset to the idle level of each pin.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '1;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_SETTLE && settle_cnt != SETTLE_LAST)
        settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    case (state)
      ST_SETTLE: if (settle_cnt == SETTLE_LAST && cs_s) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (!cs_s) begin
          state_nxt   = ST_FRAME;
          frame_start = 1'b1;
        end
      end
      ST_FRAME: begin
        if (cs_s) begin
          state_nxt  = ST_IDLE;
          frame_stop = 1'b1;
        end
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt        <= '0;
      rx_shreg       <= '0;
      tx_shreg       <= '0;
      first_byte     <= 1'b1;
      data_seen      <= 1'b0;
      reload_pending <= 1'b0;
      rx_cmd         <= '0;
      rx_data        <= '0;
      rx_index       <= '0;
      rx_cmd_stb     <= 1'b0;
      rx_data_stb    <= 1'b0;
      tx_req         <= 1'b0;
      frame_end      <= 1'b0;
    end else begin
      rx_cmd_stb  <= 1'b0;
      rx_data_stb <= 1'b0;
      tx_req      <= 1'b0;
      frame_end   <= frame_stop;

      if (frame_start) begin
        bit_cnt        <= '0;
        first_byte     <= 1'b1;
        data_seen      <= 1'b0;
        reload_pending <= 1'b0;
        rx_index       <= '0;
        tx_shreg       <= tx_data;
      end

      // Edges are still processed in the cycle CS is seen rising, so a byte
      // completing together with deselect is delivered alongside frame_end.
      if (in_frame && sck_rise) begin
        rx_shreg <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          tx_req         <= 1'b1;
          reload_pending <= 1'b1;
          if (first_byte) begin
            rx_cmd     <= rx_byte;
            rx_cmd_stb <= 1'b1;
            first_byte <= 1'b0;
          end else begin
            rx_data     <= rx_byte;
            rx_data_stb <= 1'b1;
            data_seen   <= 1'b1;
            if (data_seen && rx_index != 8'hFF)
              rx_index <= rx_index + 8'd1;
          end
        end
      end

      if (in_frame && sck_fall) begin
        if (reload_pending) begin
          tx_shreg       <= tx_data;
          reload_pending <= 1'b0;
        end else begin
          tx_shreg <= {tx_shreg[6:0], 1'b1};
        end
      end

      // Deselect discards any partial byte; placed last so it wins.
      if (frame_stop) begin
        bit_cnt        <= '0;
        reload_pending <= 1'b0;
      end
    end
  end

endmodule
